// File: rtl/mult_hilo_ctrl_pkg.sv
// mult_hilo_pkg
// Shared types for the HI/LO controller that sits in front of the
// iterative multiplier in the execute stage.
//   DATA_W    : architectural register width (multiplier operands are
//               DATA_W+1 bits, the product is 2*DATA_W bits)
//   op_e      : decoder op codes handled by this block
//   state_e   : controller states
//   op_needs_hilo : true for every op that touches HI/LO or the multiplier

package mult_hilo_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        MTHI  = 3'd3,
        MTLO  = 3'd4,
        MFHI  = 3'd5,
        MFLO  = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // NOP (and the unused 3'd7 code) never depend on HI/LO, so they never stall.
    function automatic logic op_needs_hilo(input op_e op);
        return op inside {MULT, MULTU, MTHI, MTLO, MFHI, MFLO};
    endfunction

endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// mult_hilo_ctrl_if
// Handshake between the HI/LO controller and the iterative multiplier.
//   mul_a, mul_b   : 33-bit two's complement operands (controller -> multiplier)
//   mul_valid_in   : one-cycle start pulse (controller -> multiplier)
//   mul_r          : low 64 bits of the product (multiplier -> controller)
//   mul_valid_out  : product valid this cycle (multiplier -> controller)
// Modports: master = controller side, slave = multiplier side.

interface mult_hilo_ctrl_if;
    import mult_hilo_pkg::*;

    logic [DATA_W:0]     mul_a;
    logic [DATA_W:0]     mul_b;
    logic                mul_valid_in;
    logic [2*DATA_W-1:0] mul_r;
    logic                mul_valid_out;

    modport master (
        output mul_a,
        output mul_b,
        output mul_valid_in,
        input  mul_r,
        input  mul_valid_out
    );

    modport slave (
        input  mul_a,
        input  mul_b,
        input  mul_valid_in,
        output mul_r,
        output mul_valid_out
    );

endinterface

// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl
// Owns the architectural HI/LO registers and drives the iterative multiplier.
// MULT/MULTU extend rs/rt to 33 bits and start a multiply; the product is
// written to {HI,LO} when the multiplier reports it. MTHI/MTLO/MFHI/MFLO act
// directly on HI/LO. While a multiply is in flight every HI/LO-related op is
// stalled, so MFHI/MFLO always observe the finished product.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   op_valid, op      : decoder op and its valid flag
//   rs_data, rt_data  : source operands
//   stall             : op present but not accepted; pipeline must hold it
//   mf_data           : HI or LO for an accepted MFHI/MFLO, else 0
//   hi, lo            : architectural HI/LO
//   busy              : multiply in flight (ISSUE or WAIT)
//   mul_if            : multiplier handshake (master side)

module mult_hilo_ctrl
    import mult_hilo_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid,
    input  op_e                  op,
    input  logic [DATA_W-1:0]    rs_data,
    input  logic [DATA_W-1:0]    rt_data,
    output logic                 stall,
    output logic [DATA_W-1:0]    mf_data,
    output logic [DATA_W-1:0]    hi,
    output logic [DATA_W-1:0]    lo,
    output logic                 busy,
    mult_hilo_ctrl_if.master     mul_if
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic [DATA_W-1:0]  lo_q, lo_d;
    logic [DATA_W:0]    mul_a_q, mul_a_d;
    logic [DATA_W:0]    mul_b_q, mul_b_d;
    logic               mul_valid_in;

    // Next-state and output logic. Ops are only acted upon in IDLE; in the
    // other states a HI/LO op is stalled and simply re-presented later.
    // mul_valid_out is only looked at in WAIT, so stray pulses are harmless.
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_valid_in = 1'b0;
        busy         = 1'b0;
        mf_data      = '0;
        stall        = op_valid && (state_q != IDLE) && op_needs_hilo(op);

        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    case (op)
                        MULT: begin
                            mul_a_d = {rs_data[DATA_W-1], rs_data};
                            mul_b_d = {rt_data[DATA_W-1], rt_data};
                            state_d = ISSUE;
                        end
                        MULTU: begin
                            mul_a_d = {1'b0, rs_data};
                            mul_b_d = {1'b0, rt_data};
                            state_d = ISSUE;
                        end
                        MTHI:    hi_d    = rs_data;
                        MTLO:    lo_d    = rs_data;
                        MFHI:    mf_data = hi_q;
                        MFLO:    mf_data = lo_q;
                        default: ;
                    endcase
                end
            end
            ISSUE: begin
                mul_valid_in = 1'b1;
                busy         = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (mul_if.mul_valid_out) begin
                    {hi_d, lo_d} = mul_if.mul_r;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and data registers. Reset discards any in-flight product; the
    // multiplier shares rst_n so it forgets the operation too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
        end
    end

    assign hi                  = hi_q;
    assign lo                  = lo_q;
    assign mul_if.mul_a        = mul_a_q;
    assign mul_if.mul_b        = mul_b_q;
    assign mul_if.mul_valid_in = mul_valid_in;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb_mult_hilo_ctrl
// Bench for mult_hilo_ctrl. A stand-in multiplier with a programmable latency
// answers the start pulse. A transaction-level model tracks HI/LO, the
// multiply window (accept cycle, issue cycle, completion cycle) and the
// expected operands; a compare process checks every output each cycle.
// Directed sequences add literal checks on the headline results.

module tb_mult_hilo_ctrl;
    import mult_hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    op_e         op = NOP;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        stall;
    logic        busy;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_hilo_ctrl_if mul_if ();

    mult_hilo_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .stall    (stall),
        .mf_data  (mf_data),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .mul_if   (mul_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Stand-in multiplier: captures the operands on the start pulse and raises
    // mul_valid_out exactly mul_lat cycles after that edge. Outside the valid
    // cycle mul_r carries junk so that only the valid cycle can be used.
    int          mul_lat = 1;
    logic        emu_pulse = 1'b0;
    logic        stray_pulse = 1'b0;
    logic [63:0] emu_prod = '0;
    int          emu_cnt = 0;
    logic        emu_armed = 1'b0;

    assign mul_if.mul_r         = emu_pulse ? emu_prod : 64'hDEAD_BEEF_CAFE_F00D;
    assign mul_if.mul_valid_out = emu_pulse | stray_pulse;

    initial begin
        logic               start;
        logic signed [65:0] ea, eb, ep;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                emu_armed = 1'b0;
                emu_pulse = 1'b0;
            end else begin
                start = mul_if.mul_valid_in;
                ea    = $signed(mul_if.mul_a);
                eb    = $signed(mul_if.mul_b);
                #1;
                emu_pulse = 1'b0;
                if (emu_armed) begin
                    emu_cnt--;
                    if (emu_cnt == 0) begin
                        emu_pulse = 1'b1;
                        emu_armed = 1'b0;
                    end
                end
                if (start) begin
                    ep       = ea * eb;
                    emu_prod = ep[63:0];
                    if (mul_lat <= 1) emu_pulse = 1'b1;
                    else begin
                        emu_armed = 1'b1;
                        emu_cnt   = mul_lat - 1;
                    end
                end
            end
        end
    end

    // Behavioural model. cyc numbers the cycle between two rising edges; the
    // model block sees the number of the cycle that is ending.
    longint      cyc = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [32:0] m_a = '0;
    logic [32:0] m_b = '0;
    logic [63:0] m_prod = '0;
    logic        m_fly = 1'b0;
    longint      m_issue = 0;
    longint      m_done = 0;

    function automatic logic model_busy(input longint n);
        return m_fly && (n >= m_issue) && (n <= m_done);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_a    <= '0;
            m_b    <= '0;
            m_fly  <= 1'b0;
        end else begin
            if (m_fly && cyc == m_done) begin
                m_hi  <= m_prod[63:32];
                m_lo  <= m_prod[31:0];
                m_fly <= 1'b0;
            end
            if (op_valid && !model_busy(cyc)) begin
                case (op)
                    MULT, MULTU: begin
                        if (op == MULT) begin
                            m_a    <= 33'($signed(rs_data));
                            m_b    <= 33'($signed(rt_data));
                            m_prod <= 64'($signed(rs_data)) * 64'($signed(rt_data));
                        end else begin
                            m_a    <= 33'(rs_data);
                            m_b    <= 33'(rt_data);
                            m_prod <= 64'(rs_data) * 64'(rt_data);
                        end
                        m_fly   <= 1'b1;
                        m_issue <= cyc + 1;
                        m_done  <= cyc + 1 + longint'(mul_lat);
                    end
                    MTHI:    m_hi <= rs_data;
                    MTLO:    m_lo <= rs_data;
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    logic        check_en = 1'b0;
    logic        e_busy, e_stall;
    logic [31:0] e_mf;

    always @(negedge clk) begin
        if (check_en) begin
            e_busy  = model_busy(cyc);
            e_stall = op_valid && e_busy && (op != NOP);
            e_mf    = 32'd0;
            if (op_valid && !e_busy && op == MFHI) e_mf = m_hi;
            if (op_valid && !e_busy && op == MFLO) e_mf = m_lo;
            checkOutput("busy",         64'(busy),                64'(e_busy));
            checkOutput("stall",        64'(stall),               64'(e_stall));
            checkOutput("mul_valid_in", 64'(mul_if.mul_valid_in), 64'(m_fly && cyc == m_issue));
            checkOutput("mf_data",      64'(mf_data),             64'(e_mf));
            checkOutput("hi",           64'(hi),                  64'(m_hi));
            checkOutput("lo",           64'(lo),                  64'(m_lo));
            checkOutput("mul_a",        64'(mul_if.mul_a),        64'(m_a));
            checkOutput("mul_b",        64'(mul_if.mul_b),        64'(m_b));
        end
    end

    task automatic applyStimulus(input op_e o, input logic [31:0] rs, input logic [31:0] rt);
        @(posedge clk);
        #1;
        op_valid = 1'b1;
        op       = o;
        rs_data  = rs;
        rt_data  = rt;
    endtask

    // Holds the presented op until the block accepts it; returns inside the
    // accepting cycle with the number of stalled cycles.
    task automatic holdUntilAccepted(output int stalls);
        stalls = 0;
        #1;
        while (stall && stalls < 100) begin
            @(posedge clk);
            #2;
            stalls++;
        end
        if (stall) checkOutput("stall_timeout", 64'(stall), 64'd0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            op_valid = 1'b0;
            op       = NOP;
            rs_data  = '0;
            rt_data  = '0;
        end
    endtask

    task automatic waitNotBusy();
        int budget = 0;
        while (budget < 100) begin
            @(posedge clk);
            #2;
            if (!busy) break;
            budget++;
        end
        if (busy) checkOutput("busy_timeout", 64'(busy), 64'd0);
    endtask

    task automatic runMul(input op_e o, input logic [31:0] rs, input logic [31:0] rt,
                          input int lat);
        int s;
        mul_lat = lat;
        applyStimulus(o, rs, rt);
        holdUntilAccepted(s);
        idleCycles(1);
        waitNotBusy();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        check_en = 1'b1;

        @(negedge clk);
        checkOutput("reset_hi",    64'(hi),                  64'd0);
        checkOutput("reset_lo",    64'(lo),                  64'd0);
        checkOutput("reset_busy",  64'(busy),                64'd0);
        checkOutput("reset_stall", 64'(stall),               64'd0);
        checkOutput("reset_start", 64'(mul_if.mul_valid_in), 64'd0);
        checkOutput("reset_mul_a", 64'(mul_if.mul_a),        64'd0);

        // Unsigned extremes.
        runMul(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
        checkOutput("multu_mul_a", 64'(mul_if.mul_a), 64'h0_FFFF_FFFF);
        checkOutput("multu_mul_b", 64'(mul_if.mul_b), 64'h0_FFFF_FFFF);
        checkOutput("multu_hi",    64'(hi),           64'hFFFF_FFFE);
        checkOutput("multu_lo",    64'(lo),           64'h0000_0001);

        // Signed -1 * -1, fastest multiplier.
        runMul(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        checkOutput("mult_neg_mul_a", 64'(mul_if.mul_a), 64'h1_FFFF_FFFF);
        checkOutput("mult_neg_hi",    64'(hi),           64'h0000_0000);
        checkOutput("mult_neg_lo",    64'(lo),           64'h0000_0001);

        // Most negative value times two.
        runMul(MULT, 32'h8000_0000, 32'h0000_0002, 5);
        checkOutput("mult_min_hi", 64'(hi), 64'hFFFF_FFFF);
        checkOutput("mult_min_lo", 64'(lo), 64'h0000_0000);

        // MFLO right behind a multiply waits for the new product.
        mul_lat = 4;
        applyStimulus(MULT, 32'd3, 32'd5);
        holdUntilAccepted(s);
        applyStimulus(MFLO, 32'd0, 32'd0);
        holdUntilAccepted(s);
        checkOutput("mflo_stall_cycles", 64'(s),       64'd5);
        checkOutput("mflo_after_mult",   64'(mf_data), 64'd15);
        idleCycles(1);

        // Moves to and from HI/LO never stall in IDLE.
        applyStimulus(MTHI, 32'h1234_5678, 32'd0);
        holdUntilAccepted(s);
        applyStimulus(MFHI, 32'd0, 32'd0);
        holdUntilAccepted(s);
        checkOutput("mfhi_no_stall", 64'(s),       64'd0);
        checkOutput("mfhi_value",    64'(mf_data), 64'h1234_5678);
        applyStimulus(MTLO, 32'h9ABC_DEF0, 32'd0);
        holdUntilAccepted(s);
        applyStimulus(MFLO, 32'd0, 32'd0);
        holdUntilAccepted(s);
        checkOutput("mflo_value", 64'(mf_data), 64'h9ABC_DEF0);
        checkOutput("mthi_kept",  64'(hi),      64'h1234_5678);
        idleCycles(1);

        // Back-to-back multiplies: the second starts right after completion.
        mul_lat = 2;
        applyStimulus(MULT, 32'd2, 32'd3);
        holdUntilAccepted(s);
        applyStimulus(MULTU, 32'd4, 32'd5);
        holdUntilAccepted(s);
        checkOutput("b2b_stall_cycles", 64'(s),  64'd3);
        checkOutput("b2b_first_lo",     64'(lo), 64'd6);
        idleCycles(1);
        waitNotBusy();
        checkOutput("b2b_lo", 64'(lo), 64'd20);
        checkOutput("b2b_hi", 64'(hi), 64'd0);

        // Reset in the middle of a long multiply.
        mul_lat = 10;
        applyStimulus(MULT, 32'd7, 32'd9);
        holdUntilAccepted(s);
        idleCycles(3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_hi",    64'(hi),    64'd0);
        checkOutput("rst_mid_lo",    64'(lo),    64'd0);
        checkOutput("rst_mid_busy",  64'(busy),  64'd0);
        checkOutput("rst_mid_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCycles(12);
        @(posedge clk);
        #1;
        stray_pulse = 1'b1;
        @(posedge clk);
        #1;
        stray_pulse = 1'b0;
        @(negedge clk);
        checkOutput("stray_hi",   64'(hi),   64'd0);
        checkOutput("stray_lo",   64'(lo),   64'd0);
        checkOutput("stray_busy", 64'(busy), 64'd0);

        // A multiply after the reset still works normally.
        runMul(MULT, 32'd7, 32'd9, 2);
        checkOutput("post_rst_lo", 64'(lo), 64'd63);

        idleCycles(2);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
